// File: rtl/tbird_pkg.sv
// Shared types and constants for the Thunderbird turn-lever input conditioner.
// Imported by the per-lever debouncer and the arbitrating top level.
package tbird_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } debounce_state_t;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_LEFT  = 2'd1,
      OWN_RIGHT = 2'd2
   } owner_t;

   localparam int unsigned TBIRD_DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/tbird_debounce.sv
// One lever channel: 2-flop synchronizer followed by a four-state debounce FSM
// that accepts a level only after DEBOUNCE_CYCLES consecutive stable samples.
module tbird_debounce
   import tbird_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = TBIRD_DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   // The sample that leaves a STABLE state is already the first qualifying one,
   // so the wait state accepts once DEBOUNCE_CYCLES-1 further samples are seen.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES <= 1);

   logic            sync1_q;
   logic            sync2_q;
   debounce_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         STABLE_LO: begin
            if (sync2_q) begin
               if (ONE_SHOT) begin
                  state_d = STABLE_HI;
                  cnt_d   = '0;
               end else begin
                  state_d = WAIT_HI;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         WAIT_HI: begin
            if (!sync2_q) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!sync2_q) begin
               if (ONE_SHOT) begin
                  state_d = STABLE_LO;
                  cnt_d   = '0;
               end else begin
                  state_d = WAIT_LO;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         WAIT_LO: begin
            if (sync2_q) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign level = (state_q == STABLE_HI) || (state_q == WAIT_LO);

endmodule

// File: rtl/tbird_switch_conditioner.sv
// Debounces both turn levers and grants at most one side to the sequencer;
// the first side accepted keeps ownership until its own lever is released.
module tbird_switch_conditioner
   import tbird_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = TBIRD_DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic left_raw,
   input  logic right_raw,
   output logic left,
   output logic right,
   output logic conflict
);

   logic   deb_l;
   logic   deb_r;
   owner_t owner_q, owner_d;

   tbird_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_deb_left (
      .clk  (clk),
      .reset(reset),
      .raw  (left_raw),
      .level(deb_l)
   );

   tbird_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_deb_right (
      .clk  (clk),
      .reset(reset),
      .raw  (right_raw),
      .level(deb_r)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Dropping an owner always passes through OWN_NONE, so a still-held
   // opposite lever is granted one cycle after the release.
   always_comb begin
      owner_d = owner_q;
      case (owner_q)
         OWN_NONE: begin
            if (deb_l && !deb_r) begin
               owner_d = OWN_LEFT;
            end else if (deb_r && !deb_l) begin
               owner_d = OWN_RIGHT;
            end
         end
         OWN_LEFT: begin
            if (!deb_l) begin
               owner_d = OWN_NONE;
            end
         end
         OWN_RIGHT: begin
            if (!deb_r) begin
               owner_d = OWN_NONE;
            end
         end
         default: owner_d = OWN_NONE;
      endcase
   end

   assign left     = (owner_q == OWN_LEFT);
   assign right    = (owner_q == OWN_RIGHT);
   assign conflict = deb_l & deb_r;

endmodule

// File: tb/tb_tbird_switch_conditioner.sv
// Bench for tbird_switch_conditioner with DEBOUNCE_CYCLES=4: a sample-window
// reference model feeds a scoreboard, plus explicit edge-latency checks.
module tb_tbird_switch_conditioner;

   localparam int D = 4;

   logic clk;
   logic reset;
   logic left_raw;
   logic right_raw;
   logic left;
   logic right;
   logic conflict;

   tbird_switch_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk      (clk),
      .reset    (reset),
      .left_raw (left_raw),
      .right_raw(right_raw),
      .left     (left),
      .right    (right),
      .conflict (conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [2:0] sb[$];

   // Reference model: raw samples per edge; a level is accepted once the D
   // samples taken at edges n-D-1 .. n-2 all agree.
   bit hl[0:D+1];
   bit hr[0:D+1];
   bit mdl = 1'b0;
   bit mdr = 1'b0;
   int mown = 0;

   task automatic tick(input logic l, input logic r, input logic rst);
      bit all1l, all0l, all1r, all0r;
      left_raw  = l;
      right_raw = r;
      reset     = rst;
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k <= D + 1; k++) begin
            hl[k] = 1'b0;
            hr[k] = 1'b0;
         end
         mdl  = 1'b0;
         mdr  = 1'b0;
         mown = 0;
      end else begin
         for (int k = D + 1; k > 0; k--) begin
            hl[k] = hl[k-1];
            hr[k] = hr[k-1];
         end
         hl[0] = l;
         hr[0] = r;
         case (mown)
            0: if (mdl && !mdr) mown = 1; else if (mdr && !mdl) mown = 2;
            1: if (!mdl) mown = 0;
            2: if (!mdr) mown = 0;
            default: mown = 0;
         endcase
         all1l = 1'b1; all0l = 1'b1; all1r = 1'b1; all0r = 1'b1;
         for (int k = 2; k <= D + 1; k++) begin
            all1l &= hl[k];  all0l &= !hl[k];
            all1r &= hr[k];  all0r &= !hr[k];
         end
         mdl = all1l ? 1'b1 : (all0l ? 1'b0 : mdl);
         mdr = all1r ? 1'b1 : (all0r ? 1'b0 : mdr);
      end
      sb.push_back({mown == 1, mown == 2, mdl & mdr});
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [2:0] exp;
      for (int i = 0; i < 15; i++) begin
         tick(i < 3, i < 3, i < 3);
         exp = sb.pop_front();
         checks++;
         if ({left, right, conflict} !== exp) begin
            errors++;
            $display("FAIL reset_sb i=%0d: got lrc=%b, expected %b", i, {left, right, conflict}, exp);
         end
         checks++;
         if ({left, right, conflict} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle i=%0d: got lrc=%b, expected 000", i, {left, right, conflict});
         end
      end
   endtask

   task automatic test_left_step();
      logic [2:0] exp;
      int rise_i = -1;
      int fall_i = -1;
      int right_seen = 0;
      for (int i = 0; i < 24; i++) begin
         tick(i < 12, 1'b0, 1'b0);
         exp = sb.pop_front();
         checks++;
         if ({left, right, conflict} !== exp) begin
            errors++;
            $display("FAIL left_step_sb i=%0d: got lrc=%b, expected %b", i, {left, right, conflict}, exp);
         end
         if (left === 1'b1 && rise_i < 0) rise_i = i;
         if (left === 1'b0 && rise_i >= 0 && fall_i < 0) fall_i = i;
         if (right !== 1'b0) right_seen++;
      end
      checks++;
      if (rise_i != 6) begin
         errors++;
         $display("FAIL left_rise_edge: got %0d, expected 6", rise_i);
      end
      checks++;
      if (fall_i != 18) begin
         errors++;
         $display("FAIL left_fall_edge: got %0d, expected 18", fall_i);
      end
      checks++;
      if (right_seen != 0) begin
         errors++;
         $display("FAIL left_step_right_quiet: got %0d cycles high, expected 0", right_seen);
      end
   endtask

   task automatic test_bounce();
      logic [2:0] exp;
      logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic prev = 1'b0;
      int rise_i = -1;
      int rises = 0;
      for (int i = 0; i < 30; i++) begin
         tick((i < 5) ? pat[i] : (i < 20), 1'b0, 1'b0);
         exp = sb.pop_front();
         checks++;
         if ({left, right, conflict} !== exp) begin
            errors++;
            $display("FAIL bounce_sb i=%0d: got lrc=%b, expected %b", i, {left, right, conflict}, exp);
         end
         if (left === 1'b1 && prev === 1'b0) begin
            rises++;
            if (rise_i < 0) rise_i = i;
         end
         prev = left;
      end
      checks++;
      if (rise_i != 11) begin
         errors++;
         $display("FAIL bounce_rise_edge: got %0d, expected 11", rise_i);
      end
      checks++;
      if (rises != 1) begin
         errors++;
         $display("FAIL bounce_pulse_count: got %0d, expected 1", rises);
      end
   endtask

   task automatic test_handover();
      logic [2:0] exp;
      int conf_i = -1;
      int lfall_i = -1;
      int rrise_i = -1;
      logic [1:0] lr_at_conf = 2'bxx;
      for (int i = 0; i < 40; i++) begin
         tick(i < 20, (i >= 10) && (i < 30), 1'b0);
         exp = sb.pop_front();
         checks++;
         if ({left, right, conflict} !== exp) begin
            errors++;
            $display("FAIL handover_sb i=%0d: got lrc=%b, expected %b", i, {left, right, conflict}, exp);
         end
         if (conflict === 1'b1 && conf_i < 0) begin
            conf_i = i;
            lr_at_conf = {left, right};
         end
         if (i >= 20 && left === 1'b0 && lfall_i < 0) lfall_i = i;
         if (right === 1'b1 && rrise_i < 0) rrise_i = i;
      end
      checks++;
      if (conf_i != 15) begin
         errors++;
         $display("FAIL handover_conflict_edge: got %0d, expected 15", conf_i);
      end
      checks++;
      if (lr_at_conf !== 2'b10) begin
         errors++;
         $display("FAIL handover_grant_at_conflict: got lr=%b, expected 10", lr_at_conf);
      end
      checks++;
      if (lfall_i != 26) begin
         errors++;
         $display("FAIL handover_left_fall: got %0d, expected 26", lfall_i);
      end
      checks++;
      if (rrise_i != 27) begin
         errors++;
         $display("FAIL handover_right_rise: got %0d, expected 27", rrise_i);
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] exp;
      int conf_i = -1;
      int grants = 0;
      for (int i = 0; i < 25; i++) begin
         tick(i < 15, i < 15, 1'b0);
         exp = sb.pop_front();
         checks++;
         if ({left, right, conflict} !== exp) begin
            errors++;
            $display("FAIL simul_sb i=%0d: got lrc=%b, expected %b", i, {left, right, conflict}, exp);
         end
         if (conflict === 1'b1 && conf_i < 0) conf_i = i;
         if (left !== 1'b0 || right !== 1'b0) grants++;
      end
      checks++;
      if (conf_i != 5) begin
         errors++;
         $display("FAIL simul_conflict_edge: got %0d, expected 5", conf_i);
      end
      checks++;
      if (grants != 0) begin
         errors++;
         $display("FAIL simul_no_grant: got %0d granted cycles, expected 0", grants);
      end
   endtask

   task automatic test_reset_mid_grant();
      logic [2:0] exp;
      int rise_i = -1;
      logic right_before = 1'b0;
      logic right_after = 1'bx;
      for (int i = 0; i < 35; i++) begin
         tick(1'b0, i < 25, i == 10);
         exp = sb.pop_front();
         checks++;
         if ({left, right, conflict} !== exp) begin
            errors++;
            $display("FAIL rst_grant_sb i=%0d: got lrc=%b, expected %b", i, {left, right, conflict}, exp);
         end
         if (i == 9) right_before = right;
         if (i == 10) right_after = right;
         if (i > 10 && right === 1'b1 && rise_i < 0) rise_i = i;
      end
      checks++;
      if (right_before !== 1'b1) begin
         errors++;
         $display("FAIL rst_grant_before: got right=%b, expected 1", right_before);
      end
      checks++;
      if (right_after !== 1'b0) begin
         errors++;
         $display("FAIL rst_grant_cleared: got right=%b, expected 0", right_after);
      end
      checks++;
      if (rise_i != 17) begin
         errors++;
         $display("FAIL rst_grant_requalify: got %0d, expected 17", rise_i);
      end
   endtask

   initial begin
      left_raw  = 1'b0;
      right_raw = 1'b0;
      reset     = 1'b1;
      for (int k = 0; k <= D + 1; k++) begin
         hl[k] = 1'b0;
         hr[k] = 1'b0;
      end
      test_reset();
      test_left_step();
      test_bounce();
      test_handover();
      test_simultaneous();
      test_reset_mid_grant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
